// File: rtl/decode_stage.sv
// decode_stage: RV decode into core_pkg control fields, buffered in a Depth-entry valid/ready queue.
// Optional illegal-instruction detection is built only when DECODE_ILLEGAL_CHECK_EN is defined.
`default_nettype none

package core_pkg;
   typedef enum logic [2:0] {Rtype, Itype, Stype, Btype, Utype, Jtype} inst_type_e;
   typedef enum logic [1:0] {JmpNone, JmpBr, JmpJal, JmpJalr} jump_type_e;
   typedef enum logic [2:0] {WbNone, WbAlu, WbLsu, WbJmp, WbLui, WbCsr} reg_wb_src_e;
   typedef enum logic [1:0] {Add, Funct, Op32} aluop_e;
   typedef enum logic [1:0] {MemNone, MemLoad, MemStore} mem_type_e;
   typedef enum logic [2:0] {OpCSRNone, OpCSRRW, OpCSRRS, OpCSRRC, OpCSRRdonly,
                             OpEcall, OpEbreak, OpMret} csr_op_e;

   typedef struct packed {
      inst_type_e  inst_type;
      jump_type_e  jump_type;
      reg_wb_src_e reg_wb_src;
      aluop_e      aluop;
      mem_type_e   mem_type;
      csr_op_e     csr_op;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [4:0]  rd_addr;
      logic        csr_imm;
      logic [11:0] csr_addr;
   } ctrl_t;
endpackage

module decode_stage
   import core_pkg::*;
#(
   parameter int Xlen  = 64,
   parameter int Ilen  = 32,
   parameter int Depth = 2
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [Ilen-1:0] inst_i,
   input  logic [Xlen-1:0] pc_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [Xlen-1:0] pc_o,
   output logic [Xlen-1:0] imm_o,
   output inst_type_e      inst_type_o,
   output jump_type_e      jump_type_o,
   output reg_wb_src_e     reg_wb_src_o,
   output aluop_e          aluop_o,
   output mem_type_e       mem_type_o,
   output csr_op_e         csr_op_o,
   output logic [4:0]      rs1_addr_o,
   output logic [4:0]      rs2_addr_o,
   output logic [4:0]      rd_addr_o,
   output logic            csr_imm_o,
   output logic [11:0]     csr_addr_o,
   output logic            illegal_o
);

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_ALUIMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_ALU32I = 7'b0011011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_ALU    = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_ALU32  = 7'b0111011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CW = $clog2(Depth + 1);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   ctrl_t           dec;
   logic [Xlen-1:0] dec_imm;
   logic            bad;

   assign opcode = inst_i[6:0];
   assign funct3 = inst_i[14:12];

   always_comb begin
      dec.inst_type  = Rtype;
      dec.jump_type  = JmpNone;
      dec.reg_wb_src = WbNone;
      dec.aluop      = Add;
      dec.mem_type   = MemNone;
      dec.csr_op     = OpCSRNone;
      dec.rs1_addr   = inst_i[19:15];
      dec.rs2_addr   = inst_i[24:20];
      dec.rd_addr    = inst_i[11:7];
      dec.csr_imm    = inst_i[14];
      dec.csr_addr   = inst_i[31:20];
      dec_imm        = '0;
      if (!bad) begin
         case (opcode)
            OPC_ALU:    begin dec.aluop = Funct; dec.reg_wb_src = WbAlu; end
            OPC_ALUIMM: begin
               dec.inst_type = Itype; dec.aluop = Funct; dec.reg_wb_src = WbAlu;
               dec_imm = Xlen'($signed(inst_i[31:20]));
            end
            OPC_ALU32:  begin dec.aluop = Op32; dec.reg_wb_src = WbAlu; end
            OPC_ALU32I: begin
               dec.inst_type = Itype; dec.aluop = Op32; dec.reg_wb_src = WbAlu;
               dec_imm = Xlen'($signed(inst_i[31:20]));
            end
            OPC_LOAD: begin
               dec.inst_type = Itype; dec.reg_wb_src = WbLsu; dec.mem_type = MemLoad;
               dec_imm = Xlen'($signed(inst_i[31:20]));
            end
            OPC_STORE: begin
               dec.inst_type = Stype; dec.mem_type = MemStore;
               dec_imm = Xlen'($signed({inst_i[31:25], inst_i[11:7]}));
            end
            OPC_BRANCH: begin
               dec.inst_type = Btype; dec.jump_type = JmpBr;
               dec_imm = Xlen'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
            end
            OPC_JAL: begin
               dec.inst_type = Jtype; dec.jump_type = JmpJal; dec.reg_wb_src = WbJmp;
               dec_imm = Xlen'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
            end
            OPC_JALR: begin
               dec.inst_type = Itype; dec.jump_type = JmpJalr; dec.reg_wb_src = WbJmp;
               dec_imm = Xlen'($signed(inst_i[31:20]));
            end
            OPC_LUI: begin
               dec.inst_type = Utype; dec.reg_wb_src = WbLui;
               dec_imm = Xlen'($signed({inst_i[31:12], 12'b0}));
            end
            OPC_AUIPC: begin
               dec.inst_type = Utype; dec.reg_wb_src = WbAlu;
               dec_imm = Xlen'($signed({inst_i[31:12], 12'b0}));
            end
            OPC_SYSTEM: begin
               dec.inst_type  = Itype;
               dec.reg_wb_src = WbCsr;
               dec_imm        = Xlen'(inst_i[19:15]);
               case (funct3)
                  3'd0: begin
                     if (inst_i[31:20] == 12'h000)      dec.csr_op = OpEcall;
                     else if (inst_i[31:20] == 12'h001) dec.csr_op = OpEbreak;
                     else if (inst_i[31:20] == 12'h302) dec.csr_op = OpMret;
                  end
                  3'd1, 3'd5: dec.csr_op = OpCSRRW;
                  3'd2, 3'd6: dec.csr_op = (inst_i[19:15] == 5'd0) ? OpCSRRdonly : OpCSRRS;
                  3'd3, 3'd7: dec.csr_op = (inst_i[19:15] == 5'd0) ? OpCSRRdonly : OpCSRRC;
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

`ifdef DECODE_ILLEGAL_CHECK_EN
   localparam bit RV32 = (Xlen == 32);

   always_comb begin
      bad = 1'b0;
      case (opcode)
         OPC_ALU, OPC_FENCE, OPC_LUI, OPC_AUIPC, OPC_JAL: bad = 1'b0;
         OPC_ALUIMM: bad = RV32 && (funct3 == 3'd1 || funct3 == 3'd5) && inst_i[25];
         OPC_ALU32, OPC_ALU32I: bad = RV32;
         OPC_BRANCH: bad = (funct3 == 3'd2) || (funct3 == 3'd3);
         OPC_JALR:   bad = (funct3 != 3'd0);
         OPC_LOAD:   bad = (funct3 == 3'd7) || (RV32 && (funct3 == 3'd3 || funct3 == 3'd6));
         OPC_STORE:  bad = funct3[2] || (RV32 && funct3 == 3'd3);
         OPC_SYSTEM: bad = (funct3 == 3'd4) ||
                           ((funct3 == 3'd0) && ((inst_i[19:15] != 5'd0) || (inst_i[11:7] != 5'd0) ||
                            !(inst_i[31:20] == 12'h000 || inst_i[31:20] == 12'h001 ||
                              inst_i[31:20] == 12'h302)));
         default:    bad = 1'b1;
      endcase
      // opcode already embeds inst[1:0]; listed opcodes all end in 11
      if (inst_i[1:0] != 2'b11) bad = 1'b1;
   end
`else
   assign bad = 1'b0;
`endif

   ctrl_t           ctrl_q [Depth];
   logic [Xlen-1:0] pc_q   [Depth];
   logic [Xlen-1:0] imm_q  [Depth];
   logic [PW-1:0]   head, tail;
   logic [CW-1:0]   count;
   logic            push, pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign out_valid_o = (count != '0);
   assign in_ready_o  = (count < CW'(Depth)) || out_ready_i;
   assign push        = in_valid_i && in_ready_o && !flush_i;
   assign pop         = out_valid_o && out_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < Depth; i++) begin
            ctrl_q[i] <= '0;
            pc_q[i]   <= '0;
            imm_q[i]  <= '0;
         end
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            ctrl_q[tail] <= dec;
            pc_q[tail]   <= pc_i;
            imm_q[tail]  <= dec_imm;
            tail         <= ptr_inc(tail);
         end
         if (pop) head <= ptr_inc(head);
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

`ifdef DECODE_ILLEGAL_CHECK_EN
   logic ill_q [Depth];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < Depth; i++) ill_q[i] <= 1'b0;
      end else if (push) begin
         ill_q[tail] <= bad;
      end
   end

   assign illegal_o = ill_q[head];
`else
   assign illegal_o = 1'b0;
`endif

   assign pc_o         = pc_q[head];
   assign imm_o        = imm_q[head];
   assign inst_type_o  = ctrl_q[head].inst_type;
   assign jump_type_o  = ctrl_q[head].jump_type;
   assign reg_wb_src_o = ctrl_q[head].reg_wb_src;
   assign aluop_o      = ctrl_q[head].aluop;
   assign mem_type_o   = ctrl_q[head].mem_type;
   assign csr_op_o     = ctrl_q[head].csr_op;
   assign rs1_addr_o   = ctrl_q[head].rs1_addr;
   assign rs2_addr_o   = ctrl_q[head].rs2_addr;
   assign rd_addr_o    = ctrl_q[head].rd_addr;
   assign csr_imm_o    = ctrl_q[head].csr_imm;
   assign csr_addr_o   = ctrl_q[head].csr_addr;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (Xlen=64/Depth=2 main instance, Xlen=32 side instance).
`default_nettype none

module tb_decode_stage;
   import core_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush, in_valid, out_ready;
   logic [31:0] inst;
   logic [63:0] pc;
   logic        in_ready, out_valid, csr_imm, illegal;
   logic [63:0] pc_out, imm;
   inst_type_e  inst_type;
   jump_type_e  jump_type;
   reg_wb_src_e wb_src;
   aluop_e      aluop;
   mem_type_e   mem_type;
   csr_op_e     csr_op;
   logic [4:0]  rs1, rs2, rd;
   logic [11:0] csr_addr;

   logic        in_valid32;
   logic        in_ready32, out_valid32, csr_imm32, illegal32;
   logic [31:0] pc_out32, imm32;
   inst_type_e  inst_type32;
   jump_type_e  jump_type32;
   reg_wb_src_e wb_src32;
   aluop_e      aluop32;
   mem_type_e   mem_type32;
   csr_op_e     csr_op32;
   logic [4:0]  rs1_32, rs2_32, rd_32;
   logic [11:0] csr_addr32;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   decode_stage #(.Xlen(64), .Ilen(32), .Depth(2)) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .inst_i(inst), .pc_i(pc), .out_valid_o(out_valid), .out_ready_i(out_ready), .pc_o(pc_out),
      .imm_o(imm), .inst_type_o(inst_type), .jump_type_o(jump_type), .reg_wb_src_o(wb_src),
      .aluop_o(aluop), .mem_type_o(mem_type), .csr_op_o(csr_op), .rs1_addr_o(rs1),
      .rs2_addr_o(rs2), .rd_addr_o(rd), .csr_imm_o(csr_imm), .csr_addr_o(csr_addr),
      .illegal_o(illegal));

   decode_stage #(.Xlen(32), .Ilen(32), .Depth(2)) dut32 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0), .in_valid_i(in_valid32), .in_ready_o(in_ready32),
      .inst_i(inst), .pc_i(pc[31:0]), .out_valid_o(out_valid32), .out_ready_i(1'b1),
      .pc_o(pc_out32), .imm_o(imm32), .inst_type_o(inst_type32), .jump_type_o(jump_type32),
      .reg_wb_src_o(wb_src32), .aluop_o(aluop32), .mem_type_o(mem_type32), .csr_op_o(csr_op32),
      .rs1_addr_o(rs1_32), .rs2_addr_o(rs2_32), .rd_addr_o(rd_32), .csr_imm_o(csr_imm32),
      .csr_addr_o(csr_addr32), .illegal_o(illegal32));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one instruction with the consumer ready; previous head (if any) pops on the same edge.
   task automatic push_one(input logic [31:0] i, input logic [63:0] p);
      out_ready = 1'b1;
      inst      = i;
      pc        = p;
      in_valid  = 1'b1;
      step();
      in_valid  = 1'b0;
   endtask

`ifdef DECODE_ILLEGAL_CHECK_EN
   localparam logic ILL_ON = 1'b1;
`else
   localparam logic ILL_ON = 1'b0;
`endif

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_valid32 = 1'b0;
      out_ready = 1'b0; inst = '0; pc = '0;
      step(); step();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_illegal", illegal, 1'b0);
      check("rst_pc", pc_out, 64'd0);
      check("rst_imm", imm, 64'd0);
      rst_n = 1'b1;
      step();

      // addi x1,x2,-1
      push_one(32'hFFF1_0093, 64'h1000);
      check("addi_valid", out_valid, 1'b1);
      check("addi_type", inst_type, Itype);
      check("addi_aluop", aluop, Funct);
      check("addi_wb", wb_src, WbAlu);
      check("addi_rd", rd, 5'd1);
      check("addi_rs1", rs1, 5'd2);
      check("addi_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
      check("addi_pc", pc_out, 64'h1000);
      step();
      check("addi_drained", out_valid, 1'b0);

      // Backpressure: three offers into a two-entry queue
      out_ready = 1'b0; in_valid = 1'b1;
      inst = 32'h0050_0193; pc = 64'h2000; step();
      check("bp_ready_after1", in_ready, 1'b1);
      inst = 32'h1234_5237; pc = 64'h2004; step();
      check("bp_ready_after2", in_ready, 1'b0);
      inst = 32'h0080_00EF; pc = 64'h2008; step();
      check("bp_head_stable", pc_out, 64'h2000);
      check("bp_head_imm", imm, 64'd5);
      out_ready = 1'b1; step();
      in_valid = 1'b0;
      check("bp_second_pc", pc_out, 64'h2004);
      check("bp_lui_wb", wb_src, WbLui);
      check("bp_lui_imm", imm, 64'h0000_0000_1234_5000);
      step();
      check("bp_third_pc", pc_out, 64'h2008);
      check("bp_jal_type", jump_type, JmpJal);
      check("bp_jal_wb", wb_src, WbJmp);
      check("bp_jal_imm", imm, 64'd8);
      step();
      check("bp_empty", out_valid, 1'b0);

      // Full queue, simultaneous push+pop with wrapping pointers
      out_ready = 1'b0; in_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
         inst = {12'(k), 5'd0, 3'b000, 5'd1, 7'h13}; pc = 64'h3000 + 64'(4 * k); step();
      end
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         inst = {12'(k + 2), 5'd0, 3'b000, 5'd1, 7'h13}; pc = 64'h3000 + 64'(4 * (k + 2));
         step();
         check("pp_pc", pc_out, 64'h3000 + 64'(4 * (k + 1)));
         check("pp_imm", imm, 64'(k + 1));
      end
      in_valid = 1'b0;
      step();
      check("pp_tail_pc", pc_out, 64'h3000 + 64'(4 * 11));
      check("pp_tail_valid", out_valid, 1'b1);
      step();
      check("pp_drained", out_valid, 1'b0);

      // Flush with two queued and a same-cycle offer
      out_ready = 1'b0; in_valid = 1'b1;
      inst = 32'h0050_0193; pc = 64'h4000; step();
      pc = 64'h4004; step();
      flush = 1'b1; pc = 64'h4008; #1;
      check("flush_in_ready", in_ready, 1'b0);
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_valid", out_valid, 1'b0);
      out_ready = 1'b1; step();
      check("flush_stays_empty", out_valid, 1'b0);
      push_one(32'h0050_0193, 64'h5000);
      check("flush_next_pc", pc_out, 64'h5000);

      // Decode table
      push_one(32'h3000_22F3, 64'h6000);    // csrrs x5,mstatus,x0
      check("csrrs_op", csr_op, OpCSRRdonly);
      check("csrrs_wb", wb_src, WbCsr);
      check("csrrs_addr", csr_addr, 12'h300);
      check("csrrs_rd", rd, 5'd5);
      push_one(32'h3050_9073, 64'h6004);    // csrrw x0,mtvec,x1
      check("csrrw_op", csr_op, OpCSRRW);
      check("csrrw_csrimm", csr_imm, 1'b0);
      push_one(32'h0000_0073, 64'h6008);    // ecall
      check("ecall_op", csr_op, OpEcall);
      push_one(32'h3020_0073, 64'h600C);    // mret
      check("mret_op", csr_op, OpMret);
      push_one(32'hFE20_AE23, 64'h6010);    // sw x2,-4(x1)
      check("sw_type", inst_type, Stype);
      check("sw_mem", mem_type, MemStore);
      check("sw_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
      push_one(32'hFE00_0CE3, 64'h6014);    // beq x0,x0,-8
      check("beq_type", inst_type, Btype);
      check("beq_jump", jump_type, JmpBr);
      check("beq_imm", imm, 64'hFFFF_FFFF_FFFF_FFF8);
      push_one(32'h0020_81BB, 64'h6018);    // addw on RV64
      check("addw64_aluop", aluop, Op32);
      check("addw64_illegal", illegal, 1'b0);
      push_one(32'h0000_000F, 64'h601C);    // fence
      check("fence_wb", wb_src, WbNone);
      check("fence_aluop", aluop, Add);
      push_one(32'h0000_0000, 64'h6020);    // inst[1:0] = 00
      check("zero_illegal", illegal, ILL_ON);
      check("zero_wb", wb_src, WbNone);
      step();

      // addw on the RV32 instance
      inst = 32'h0020_81BB; pc = 64'h7000; in_valid32 = 1'b1;
      step();
      in_valid32 = 1'b0;
      check("addw32_valid", out_valid32, 1'b1);
      check("addw32_illegal", illegal32, ILL_ON);
      check("addw32_aluop", aluop32, ILL_ON ? Add : Op32);
      step();

      // Asynchronous reset mid-burst
      out_ready = 1'b0; in_valid = 1'b1;
      inst = 32'h0050_0193; pc = 64'h8000; step();
      pc = 64'h8004; step();
      check("burst_full", in_ready, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", out_valid, 1'b0);
      check("arst_ready", in_ready, 1'b1);
      check("arst_pc", pc_out, 64'd0);
      in_valid = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      check("post_rst_valid", out_valid, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
